// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared IF-stage state encoding and constants
package inst_fetch_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_CANCEL = 3'd4
    } if_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] PC_INITIAL = 32'hbfc0_0000;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch master feeding ID
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = inst_fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    input  logic        id_allowin,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    output logic        pc_enable,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    if_state_e   state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_adel_q, if_adel_d;
    logic        pc_misaligned;
    logic        req_fire;

    assign pc_misaligned = |fetch_pc[1:0];
    assign inst_req      = (state_q == S_REQ) && !pc_misaligned;
    assign inst_addr     = fetch_pc;
    assign req_fire      = inst_req && inst_addr_ok;
    assign pc_enable     = flush || ((state_q == S_HOLD) && id_allowin);

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // An accepted request must still be drained even if redirected
                if (flush)              state_d = req_fire ? S_CANCEL : S_REQ;
                else if (pc_misaligned) state_d = S_HOLD;
                else if (req_fire)      state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush)             state_d = inst_data_ok ? S_REQ : S_CANCEL;
                else if (inst_data_ok) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (flush || id_allowin) state_d = S_REQ;
            end
            S_CANCEL: begin
                if (inst_data_ok) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : bundle_next
        req_pc_d   = req_fire ? fetch_pc : req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_adel_d  = if_adel_q;
        if (flush) begin
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pc_misaligned) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc;
                        if_inst_d  = NOP_INST;
                        if_adel_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_inst_d  = inst_rdata;
                        if_adel_d  = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (id_allowin) if_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_pc_q   <= 32'd0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            if_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_adel_q  <= if_adel_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_adel  = if_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed vector table plus randomized model check of inst_fetch
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] B  = PC_INITIAL;
    localparam logic [31:0] A1 = 32'h1000_0001;
    localparam logic [31:0] A2 = 32'h1000_0002;
    localparam logic [31:0] A3 = 32'h1000_0003;
    localparam logic [31:0] A4 = 32'h1000_0004;
    localparam logic [31:0] A5 = 32'h1000_0005;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        flush;
    logic [31:0] flush_tgt;
    logic        id_allowin;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        pc_enable;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch #(.NOP_INST(NOP_INST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_pc     (fetch_pc),
        .flush        (flush),
        .id_allowin   (id_allowin),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .pc_enable    (pc_enable),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [31:0] tgt;
        logic        al;
        logic        ao;
        logic        dk;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        pen;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        adel;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t mk(input logic fl, input logic [31:0] tgt, input logic al,
                                input logic ao, input logic dk, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr, input logic pen,
                                input logic vv, input logic [31:0] ipc, input logic [31:0] inst,
                                input logic adel);
        vec_t r;
        r.fl = fl; r.tgt = tgt; r.al = al; r.ao = ao; r.dk = dk; r.rd = rd;
        r.req = req; r.addr = addr; r.pen = pen; r.v = vv; r.ipc = ipc; r.inst = inst;
        r.adel = adel;
        return r;
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'ha5c3, a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [31:0] tgt, input logic al,
                         input logic ao, input logic dk, input logic [31:0] rd);
        flush = fl; flush_tgt = tgt; id_allowin = al;
        inst_addr_ok = ao; inst_data_ok = dk; inst_rdata = rd;
        @(negedge clk);
    endtask

    // Environment PC register: advances or redirects when enabled
    task automatic adv(input logic pen);
        @(posedge clk);
        #1;
        if (pen) fetch_pc = flush ? flush_tgt : fetch_pc + 32'd4;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        fetch_pc = PC_INITIAL;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Transaction-level reference state for the random phase
    bit          m_started, m_have, m_out, m_stale;
    logic [31:0] m_pc, m_inst, m_out_pc;
    logic        m_adel;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        e_req, e_pen;
    logic [31:0] r;
    string       tag;

    initial begin
        rst_n = 1'b0;
        flush = 0; flush_tgt = 0; id_allowin = 0; inst_addr_ok = 0;
        inst_data_ok = 0; inst_rdata = 0; fetch_pc = PC_INITIAL;
        #2;
        chk("reset.if_valid",  32'(if_valid),  0);
        chk("reset.if_pc",     if_pc,          0);
        chk("reset.if_inst",   if_inst,        0);
        chk("reset.if_adel",   32'(if_adel),   0);
        chk("reset.inst_req",  32'(inst_req),  0);
        chk("reset.pc_enable", 32'(pc_enable), 0);

        //            fl tgt       al ao dk rd            req addr     pen v ipc      inst      adel
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           0, B,        0, 0, 0,       0,        0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B,        0, 0, 0,       0,        0));
        tbl.push_back(mk(0, 0,        1, 0, 1, A1,          0, B,        0, 0, 0,       0,        0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B,        1, 1, B,       A1,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+4,      0, 0, B,       A1,       0));
        tbl.push_back(mk(0, 0,        1, 0, 1, A2,          0, B+4,      0, 0, B,       A1,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+4,      1, 1, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           1, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           1, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        1, 0, 1, A3,          0, B+8,      0, 0, B+4,     A2,       0));
        tbl.push_back(mk(0, 0,        0, 1, 0, 0,           0, B+8,      0, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        0, 1, 0, 0,           0, B+8,      0, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        0, 1, 1, 32'hffffffff, 0, B+8,     0, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        0, 1, 0, 0,           0, B+8,      0, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        0, 1, 0, 0,           0, B+8,      0, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+8,      1, 1, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+12,     0, 0, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        1, 0, 1, A4,          0, B+12,     0, 0, B+8,     A3,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+12,     1, 1, B+12,    A4,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+16,     0, 0, B+12,    A4,       0));
        tbl.push_back(mk(1, B+'h100,  1, 0, 0, 0,           0, B+16,     1, 0, B+12,    A4,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           0, B+'h100,  0, 0, B+12,    A4,       0));
        tbl.push_back(mk(0, 0,        1, 1, 1, 32'hdeadbeef, 0, B+'h100, 0, 0, B+12,   A4,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+'h100,  0, 0, B+12,    A4,       0));
        tbl.push_back(mk(1, B+'h200,  1, 0, 1, 32'hbadbad00, 0, B+'h100, 1, 0, B+12,   A4,       0));
        tbl.push_back(mk(1, B+2,      1, 0, 0, 0,           1, B+'h200,  1, 0, B+12,    A4,       0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           0, B+2,      0, 0, B+12,    A4,       0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 0,           0, B+2,      0, 1, B+2,     NOP_INST, 1));
        tbl.push_back(mk(1, B+'h380,  0, 0, 0, 0,           0, B+2,      1, 1, B+2,     NOP_INST, 1));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0,           1, B+'h380,  0, 0, B+2,     NOP_INST, 1));
        tbl.push_back(mk(0, 0,        1, 0, 1, A5,          0, B+'h380,  0, 0, B+2,     NOP_INST, 1));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           0, B+'h380,  1, 1, B+'h380, A5,       0));
        tbl.push_back(mk(0, 0,        1, 0, 0, 0,           1, B+'h384,  0, 0, B+'h380, A5,       0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.fl, v.tgt, v.al, v.ao, v.dk, v.rd);
            chk($sformatf("row%0d.inst_req", i),  32'(inst_req),  32'(v.req));
            chk($sformatf("row%0d.inst_addr", i), inst_addr,      v.addr);
            chk($sformatf("row%0d.pc_enable", i), 32'(pc_enable), 32'(v.pen));
            chk($sformatf("row%0d.if_valid", i),  32'(if_valid),  32'(v.v));
            chk($sformatf("row%0d.if_pc", i),     if_pc,          v.ipc);
            chk($sformatf("row%0d.if_inst", i),   if_inst,        v.inst);
            chk($sformatf("row%0d.if_adel", i),   32'(if_adel),   32'(v.adel));
            adv(v.pen);
        end

        // Reset asserted while a read is outstanding; late data_ok must be ignored
        drive(0, 0, 1, 1, 0, 0);
        chk("midrst.req_before", 32'(inst_req), 1);
        adv(0);
        drive(0, 0, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst.if_valid",  32'(if_valid),  0);
        chk("midrst.if_pc",     if_pc,          0);
        chk("midrst.if_inst",   if_inst,        0);
        chk("midrst.inst_req",  32'(inst_req),  0);
        chk("midrst.pc_enable", 32'(pc_enable), 0);
        inst_data_ok = 1'b1; inst_rdata = 32'hffff_ffff;
        @(posedge clk);
        #1 rst_n = 1'b1;
        fetch_pc = PC_INITIAL;
        drive(0, 0, 1, 0, 1, 32'hffff_ffff);
        chk("midrst.idle_req", 32'(inst_req), 0);
        adv(0);
        drive(0, 0, 1, 0, 1, 32'hffff_ffff);
        chk("midrst.first_req",  32'(inst_req), 1);
        chk("midrst.first_addr", inst_addr,     B);
        chk("midrst.valid_a",    32'(if_valid), 0);
        adv(0);
        drive(0, 0, 1, 0, 0, 0);
        chk("midrst.valid_b",    32'(if_valid), 0);
        chk("midrst.still_req",  32'(inst_req), 1);

        // Randomized run against the transaction-level model
        do_reset();
        m_started = 0; m_have = 0; m_out = 0; m_stale = 0;
        m_pc = 0; m_inst = 0; m_adel = 0; m_out_pc = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom();
            flush_tgt = {r[31:2], 2'b00};
            if ($urandom_range(0, 7) == 0) flush_tgt[1:0] = 2'($urandom_range(1, 3));
            flush        = ($urandom_range(0, 9) == 0);
            id_allowin   = ($urandom_range(0, 2) != 0);
            inst_addr_ok = 1'($urandom_range(0, 1));
            if (mem_busy) begin
                inst_data_ok = (mem_cnt == 0);
                inst_rdata   = inst_data_ok ? memword(mem_addr) : $urandom();
            end else begin
                inst_data_ok = ($urandom_range(0, 15) == 0);
                inst_rdata   = $urandom();
            end
            @(negedge clk);
            e_req = m_started && !m_have && !m_out && (fetch_pc[1:0] == 2'b00);
            e_pen = flush || (m_have && id_allowin);
            tag = $sformatf("rnd%0d", c);
            chk({tag, ".inst_req"},  32'(inst_req),  32'(e_req));
            chk({tag, ".inst_addr"}, inst_addr,      fetch_pc);
            chk({tag, ".pc_enable"}, 32'(pc_enable), 32'(e_pen));
            chk({tag, ".if_valid"},  32'(if_valid),  32'(m_have));
            chk({tag, ".if_pc"},     if_pc,          m_pc);
            chk({tag, ".if_inst"},   if_inst,        m_inst);
            chk({tag, ".if_adel"},   32'(if_adel),   32'(m_adel));

            if (!m_started) begin
                m_started = 1;
            end else if (m_have) begin
                if (flush || id_allowin) m_have = 0;
            end else if (m_out) begin
                if (inst_data_ok) begin
                    m_out = 0;
                    if (!m_stale && !flush) begin
                        m_have = 1; m_pc = m_out_pc; m_inst = memword(m_out_pc); m_adel = 0;
                    end
                end else if (flush) begin
                    m_stale = 1;
                end
            end else if (fetch_pc[1:0] != 2'b00) begin
                if (!flush) begin
                    m_have = 1; m_pc = fetch_pc; m_inst = NOP_INST; m_adel = 1;
                end
            end else if (inst_addr_ok) begin
                m_out = 1; m_out_pc = fetch_pc; m_stale = flush;
            end

            if (e_req && inst_addr_ok) begin
                mem_busy = 1; mem_addr = fetch_pc; mem_cnt = $urandom_range(0, 3);
            end else if (mem_busy) begin
                if (inst_data_ok) mem_busy = 0;
                else if (mem_cnt > 0) mem_cnt--;
            end
            adv(e_pen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
